// File: rtl/keypad_pkg.sv
// Shared types, keymap and scan-reduction helper for the keypad operand entry path.
// A snapshot bit is set when its key reads low; bit index is {row, col}.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_X     = 2'd0,
        ST_Y     = 2'd1,
        ST_M     = 2'd2,
        ST_READY = 2'd3
    } entry_stage_e;

    typedef struct packed {
        logic       pressed;
        logic [3:0] code;
    } scan_result_t;

    localparam scan_result_t NO_KEY = '{pressed: 1'b0, code: 4'h0};

    // Row-major: index = row * 4 + col, col0 leftmost.
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    // Exactly one key down yields a press. None or several (ghosting) yield NO_KEY, so that
    // every not-pressed scan compares equal in the debouncer.
    function automatic scan_result_t reduce_snapshot(input logic [15:0] down);
        scan_result_t res;
        int unsigned  n;
        res = NO_KEY;
        n   = 0;
        for (int i = 0; i < 16; i++) begin
            if (down[i]) begin
                n++;
                res.code = KEYMAP[i];
            end
        end
        res.pressed = (n == 1);
        if (n != 1) begin
            res.code = 4'h0;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column scanner for a 4x4 keypad: row synchronizer, slot divider, column drive,
// full-scan snapshot, debounce and the one-cycle key_valid / key_code output.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clock_100Mhz,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int unsigned     DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam int unsigned     CntW    = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CntW-1:0] CntSat  = CntW'(DEBOUNCE_SCANS);

    logic [3:0]      row_meta_q, row_sync_q;
    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      col_idx_q, col_idx_d;
    logic [3:0]      col_q, col_d;
    logic [15:0]     snap_q, snap_d, snap_full;
    scan_result_t    prev_q, prev_d;
    scan_result_t    stable_q, stable_d;
    scan_result_t    scan_res;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            key_valid_q, key_valid_d;
    logic [3:0]      key_code_q, key_code_d;
    logic            slot_end;

    always_comb begin
        div_d     = div_q;
        col_idx_d = col_idx_q;
        col_d     = col_q;
        snap_d    = snap_q;
        prev_d    = prev_q;
        cnt_d     = cnt_q;
        stable_d  = stable_q;

        // Current column's rows merged in, so the col3 sample completes the scan this cycle.
        snap_full = snap_q;
        for (int r = 0; r < 4; r++) begin
            snap_full[r * 4 + int'(col_idx_q)] = ~row_sync_q[r];
        end
        scan_res = reduce_snapshot(snap_full);
        slot_end = (div_q == DivLast);

        if (slot_end) begin
            div_d     = '0;
            col_idx_d = col_idx_q + 2'd1;
            col_d     = ~(4'b0001 << col_idx_d);
            snap_d    = snap_full;
            if (col_idx_q == 2'd3) begin
                prev_d = scan_res;
                if (scan_res == prev_q) begin
                    cnt_d = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;
                end else begin
                    cnt_d = CntW'(1);
                end
                if (cnt_d == CntSat) begin
                    stable_d = scan_res;
                end
            end
        end else begin
            div_d = div_q + 1'b1;
        end

        // Only a released->pressed transition is a new key; key-to-key changes are not.
        key_valid_d = stable_d.pressed && !stable_q.pressed;
        key_code_d  = key_valid_d ? stable_d.code : key_code_q;
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            row_meta_q  <= 4'hF;
            row_sync_q  <= 4'hF;
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            col_q       <= 4'b1110;
            snap_q      <= '0;
            prev_q      <= NO_KEY;
            stable_q    <= NO_KEY;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            row_meta_q  <= row;
            row_sync_q  <= row_meta_q;
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            col_q       <= col_d;
            snap_q      <= snap_d;
            prev_q      <= prev_d;
            stable_q    <= stable_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign col       = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad front end for the ALU: scans and debounces the keypad, then loads accepted keys
// into operand X, operand Y and opcode M in that order.
module keypad_operand_entry
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 100000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clock_100Mhz,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [3:0] X,
    output logic [3:0] Y,
    output logic [3:0] M,
    output logic [1:0] entry_stage,
    output logic       operands_ready
);

    logic [3:0]   scan_code;
    logic         scan_valid;
    entry_stage_e stage_q, stage_d;
    logic [3:0]   x_q, x_d, y_q, y_d, m_q, m_d;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scanner (
        .clock_100Mhz (clock_100Mhz),
        .reset        (reset),
        .row          (row),
        .col          (col),
        .key_code     (scan_code),
        .key_valid    (scan_valid)
    );

    always_comb begin
        stage_d = stage_q;
        x_d     = x_q;
        y_d     = y_q;
        m_d     = m_q;
        if (scan_valid) begin
            case (stage_q)
                ST_X: begin
                    x_d     = scan_code;
                    stage_d = ST_Y;
                end
                ST_Y: begin
                    y_d     = scan_code;
                    stage_d = ST_M;
                end
                ST_M: begin
                    m_d     = scan_code;
                    stage_d = ST_READY;
                end
                ST_READY: begin
                    // A key after a complete entry starts the next one.
                    x_d     = scan_code;
                    y_d     = 4'h0;
                    m_d     = 4'h0;
                    stage_d = ST_Y;
                end
                default: stage_d = ST_X;
            endcase
        end
    end

    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            stage_q <= ST_X;
            x_q     <= 4'h0;
            y_q     <= 4'h0;
            m_q     <= 4'h0;
        end else begin
            stage_q <= stage_d;
            x_q     <= x_d;
            y_q     <= y_d;
            m_q     <= m_d;
        end
    end

    assign key_code       = scan_code;
    assign key_valid      = scan_valid;
    assign X              = x_q;
    assign Y              = y_q;
    assign M              = m_q;
    assign entry_stage    = stage_q;
    assign operands_ready = (stage_q == ST_READY);

endmodule
